// File: rtl/riscv_muldiv_unit_if.sv
// Issue/response bundle between the datapath and the multiply/divide unit.
// The datapath drives the request side; the unit drives busy/done/result.
interface riscv_muldiv_unit_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic              flush;
    logic [2:0]        funct3;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;

    modport master (
        output start, flush, funct3, op_a, op_b,
        input  busy, done, result
    );

    modport slave (
        input  start, flush, funct3, op_a, op_b,
        output busy, done, result
    );
endinterface

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide: shift-add multiply and restoring divide,
// one bit per cycle on operand magnitudes, with sign fix-up on the final iteration.
module riscv_muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    riscv_muldiv_unit_if.slave   bus
);
    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          funct3_q;
    logic                neg_q;
    logic                rneg_q;
    logic [DATA_W:0]     acc_q;
    logic [DATA_W-1:0]   lo_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   result_q;
    logic                busy_q;
    logic                done_q;

    // Accept-side decode
    logic                a_signed, b_signed, a_neg, b_neg;
    logic [DATA_W-1:0]   mag_a, mag_b;
    logic                is_div, div_zero, div_ovf;
    logic [DATA_W-1:0]   corner_res;

    always_comb begin
        is_div   = bus.funct3[2];
        a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) || (is_div && !bus.funct3[0]);
        b_signed = (bus.funct3 == 3'b001) || (is_div && !bus.funct3[0]);
        a_neg    = a_signed && bus.op_a[DATA_W-1];
        b_neg    = b_signed && bus.op_b[DATA_W-1];
        mag_a    = a_neg ? -bus.op_a : bus.op_a;
        mag_b    = b_neg ? -bus.op_b : bus.op_b;
        div_zero = is_div && (bus.op_b == '0);
        div_ovf  = is_div && !bus.funct3[0] && (bus.op_a == MIN_VAL) && (bus.op_b == '1);
        corner_res = '0;
        if (div_zero) begin
            corner_res = bus.funct3[1] ? bus.op_a : '1;
        end else if (div_ovf) begin
            corner_res = bus.funct3[1] ? '0 : bus.op_a;
        end
    end

    // One iteration of the datapath, plus the signed final result it would produce
    logic [DATA_W:0]       mul_sum;
    logic [DATA_W:0]       div_shift;
    logic                  div_ge;
    logic [DATA_W:0]       acc_d;
    logic [DATA_W-1:0]     lo_d;
    logic [2*DATA_W-1:0]   prod_fix;
    logic [DATA_W-1:0]     quo_fix, rem_fix, final_d;

    always_comb begin
        mul_sum   = {1'b0, acc_q[DATA_W-1:0]} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_shift = {acc_q[DATA_W-1:0], lo_q[DATA_W-1]};
        div_ge    = div_shift >= {1'b0, b_q};
        if (funct3_q[2]) begin
            acc_d = div_ge ? (div_shift - {1'b0, b_q}) : div_shift;
            lo_d  = {lo_q[DATA_W-2:0], div_ge};
        end else begin
            acc_d = {1'b0, mul_sum[DATA_W:1]};
            lo_d  = {mul_sum[0], lo_q[DATA_W-1:1]};
        end
        prod_fix = neg_q ? -{acc_d[DATA_W-1:0], lo_d} : {acc_d[DATA_W-1:0], lo_d};
        quo_fix  = neg_q ? -lo_d : lo_d;
        rem_fix  = rneg_q ? -acc_d[DATA_W-1:0] : acc_d[DATA_W-1:0];
        case (funct3_q)
            3'b000:         final_d = prod_fix[DATA_W-1:0];
            3'b001, 3'b010,
            3'b011:         final_d = prod_fix[2*DATA_W-1:DATA_W];
            3'b100, 3'b101: final_d = quo_fix;
            default:        final_d = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            funct3_q <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            acc_q    <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (bus.flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        funct3_q <= bus.funct3;
                        neg_q    <= a_neg ^ b_neg;
                        rneg_q   <= a_neg;
                        acc_q    <= '0;
                        lo_q     <= mag_a;
                        b_q      <= mag_b;
                        cnt_q    <= CNT_W'(DATA_W);
                        if (div_zero || div_ovf) begin
                            result_q <= corner_res;
                            state_q  <= DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            state_q <= CALC;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end else begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        result_q <= final_d;
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Directed bench for riscv_muldiv_unit: 32-bit instance for the main op set,
// 64-bit instance for the wide MULHU case.
module tb_riscv_muldiv_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    riscv_muldiv_unit_if #(.DATA_W(32)) bus32();
    riscv_muldiv_unit_if #(.DATA_W(64)) bus64();

    riscv_muldiv_unit #(.DATA_W(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));
    riscv_muldiv_unit #(.DATA_W(64)) dut64 (.clk(clk), .reset(reset), .bus(bus64.slave));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic run32(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        int busy_cnt;
        @(negedge clk);
        bus32.funct3 = f; bus32.op_a = a; bus32.op_b = b; bus32.start = 1'b1;
        @(posedge clk); #1;
        bus32.start = 1'b0;
        lat = 0; busy_cnt = 0;
        while (!bus32.done && lat < 200) begin
            if (bus32.busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        $display("op %s a=0x%08h b=0x%08h result=0x%08h edges=%0d", tag, a, b, bus32.result, lat);
        check({tag, " result"}, 64'(bus32.result), 64'(exp));
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " busy cycles"}, 64'(busy_cnt), 64'(exp_lat));
        @(posedge clk); #1;
        check({tag, " done width"}, 64'(bus32.done), 64'd0);
    endtask

    initial begin
        int lat;
        int seen;
        reset = 1'b0;
        bus32.start = 0; bus32.flush = 0; bus32.funct3 = 0; bus32.op_a = 0; bus32.op_b = 0;
        bus64.start = 0; bus64.flush = 0; bus64.funct3 = 0; bus64.op_a = 0; bus64.op_b = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(bus32.busy), 64'd0);
        check("reset done", 64'(bus32.done), 64'd0);
        check("reset result", 64'(bus32.result), 64'd0);
        check("reset result64", bus64.result, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Multiplies
        run32("MUL",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 32);
        run32("MULH",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32);
        run32("MULHU",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32);
        run32("MULHSU", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32);

        // Divides
        run32("DIV",  3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32);
        run32("REM",  3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32);
        run32("DIVU", 3'b101, 32'd100,      32'd7, 32'd14,       32);
        run32("REMU", 3'b111, 32'd100,      32'd7, 32'd2,        32);

        // Corner cases resolve at accept
        run32("DIV0",    3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 0);
        run32("DIVOVF",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
        run32("REMOVF",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0);
        run32("REMU0",   3'b111, 32'd5,        32'd0,        32'd5,        0);

        // Flush with start in IDLE: nothing accepted
        @(negedge clk);
        bus32.funct3 = 3'b000; bus32.op_a = 32'd3; bus32.op_b = 32'd4;
        bus32.start = 1'b1; bus32.flush = 1'b1;
        @(posedge clk); #1;
        bus32.start = 1'b0; bus32.flush = 1'b0;
        check("idle flush busy", 64'(bus32.busy), 64'd0);
        check("idle flush done", 64'(bus32.done), 64'd0);

        // Flush on the 10th CALC cycle
        @(negedge clk);
        bus32.funct3 = 3'b000; bus32.op_a = 32'd3; bus32.op_b = 32'd4; bus32.start = 1'b1;
        @(posedge clk); #1;
        bus32.start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        check("flush pre busy", 64'(bus32.busy), 64'd1);
        bus32.flush = 1'b1;
        @(posedge clk); #1;
        bus32.flush = 1'b0;
        check("flush busy", 64'(bus32.busy), 64'd0);
        check("flush done", 64'(bus32.done), 64'd0);
        check("flush result", 64'(bus32.result), 64'd5);
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (bus32.done) seen++; end
        check("flush no done", 64'(seen), 64'd0);
        $display("op FLUSH result=0x%08h", bus32.result);
        run32("DIVU93", 3'b101, 32'd9, 32'd3, 32'd3, 32);

        // start held through CALC is ignored; op on DONE cycle accepted back-to-back
        @(negedge clk);
        bus32.funct3 = 3'b101; bus32.op_a = 32'd100; bus32.op_b = 32'd7; bus32.start = 1'b1;
        @(posedge clk); #1;
        bus32.funct3 = 3'b000; bus32.op_a = 32'd6; bus32.op_b = 32'd7;
        lat = 0;
        while (!bus32.done && lat < 200) begin @(posedge clk); #1; lat++; end
        check("hold result", 64'(bus32.result), 64'd14);
        check("hold latency", 64'(lat), 64'd32);
        $display("op HOLD DIVU result=0x%08h edges=%0d", bus32.result, lat);
        bus32.funct3 = 3'b101; bus32.op_a = 32'd1000; bus32.op_b = 32'd10;
        @(posedge clk); #1;
        bus32.start = 1'b0;
        check("b2b busy", 64'(bus32.busy), 64'd1);
        check("b2b held result", 64'(bus32.result), 64'd14);
        lat = 0;
        while (!bus32.done && lat < 200) begin @(posedge clk); #1; lat++; end
        check("b2b result", 64'(bus32.result), 64'd100);
        check("b2b latency", 64'(lat), 64'd32);
        $display("op B2B DIVU result=0x%08h edges=%0d", bus32.result, lat);

        // Reset mid-divide
        @(negedge clk);
        bus32.funct3 = 3'b101; bus32.op_a = 32'd100; bus32.op_b = 32'd7; bus32.start = 1'b1;
        @(posedge clk); #1;
        bus32.start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check("rst busy", 64'(bus32.busy), 64'd0);
        check("rst done", 64'(bus32.done), 64'd0);
        check("rst result", 64'(bus32.result), 64'd0);
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (bus32.done) seen++; end
        check("rst no done", 64'(seen), 64'd0);
        $display("op RESET result=0x%08h", bus32.result);
        run32("DIVU_RPT", 3'b101, 32'd100, 32'd7, 32'd14, 32);

        // 64-bit MULHU
        @(negedge clk);
        bus64.funct3 = 3'b011; bus64.op_a = '1; bus64.op_b = 64'd2; bus64.start = 1'b1;
        @(posedge clk); #1;
        bus64.start = 1'b0;
        lat = 0;
        while (!bus64.done && lat < 300) begin @(posedge clk); #1; lat++; end
        check("MULHU64 result", bus64.result, 64'd1);
        check("MULHU64 latency", 64'(lat), 64'd64);
        $display("op MULHU64 result=0x%016h edges=%0d", bus64.result, lat);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
